// File: rtl/yuyv_frame_writer_pkg.sv
// Frame-buffer constants shared by the YUYV frame writer and the 8x8 block reader.
package yuyv_frame_writer_pkg;
  localparam int FRAME_WIDTH  = 320;
  localparam int FRAME_HEIGHT = 200;
  localparam int FRAME_BPP    = 2;
  localparam int FRAME_ADDR_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } wr_state_t;
endpackage

// File: rtl/yuyv_frame_writer_wr_addr_fifo.sv
// Synchronous address+data FIFO that buffers camera bytes between memory grant windows.
module wr_addr_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/yuyv_frame_writer.sv
// Captures one OV7670 YUYV frame and writes it in raster order into the shared frame memory,
// buffering bytes through a small FIFO while the block reader withholds the write grant.
module yuyv_frame_writer
  import yuyv_frame_writer_pkg::*;
#(
  parameter int WIDTH      = FRAME_WIDTH,
  parameter int HEIGHT     = FRAME_HEIGHT,
  parameter int ADDR_W     = FRAME_ADDR_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_req,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_valid,
  input  logic [7:0]        cam_data,
  input  logic              mem_wr_acc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int LINE_B = FRAME_BPP * WIDTH;
  localparam int BW     = $clog2(LINE_B + 1);
  localparam int LW     = $clog2(HEIGHT + 1);
  localparam int FW     = ADDR_W + 8;

  wr_state_t           state;
  logic                req_d, vs_d, href_d;
  logic [LW-1:0]       line_cnt;
  logic [BW-1:0]       byte_cnt;
  logic                req_rise, vs_fall, vs_rise, href_fall;
  logic                accept, overflow;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]       fifo_head;
  logic [ADDR_W-1:0]   wr_addr;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign req_rise  = capture_req & ~req_d;
  assign vs_fall   = ~cam_vsync & vs_d;
  assign vs_rise   = cam_vsync & ~vs_d;
  assign href_fall = ~cam_href & href_d;

  assign accept   = (state == ST_CAPTURE) & cam_valid & cam_href &
                    (line_cnt < LW'(HEIGHT)) & (byte_cnt < BW'(LINE_B));
  assign fifo_pop = ~fifo_empty & mem_wr_acc;
  assign overflow = accept & fifo_full & ~fifo_pop;
  assign wr_addr  = ADDR_W'(line_cnt) * ADDR_W'(LINE_B) + ADDR_W'(byte_cnt);

  assign mem_wr   = fifo_pop;
  // Head is masked while empty so the bus idles at zero rather than stale storage.
  assign mem_addr = fifo_empty ? '0 : fifo_head[FW-1:8];
  assign mem_data = fifo_empty ? '0 : fifo_head[7:0];

  wr_addr_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .wdata   ({wr_addr, cam_data}),
    .pop     (fifo_pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      req_d      <= 1'b0;
      vs_d       <= 1'b0;
      href_d     <= 1'b0;
      line_cnt   <= '0;
      byte_cnt   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      req_d      <= capture_req;
      vs_d       <= cam_vsync;
      href_d     <= cam_href;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE:
          if (req_rise) begin
            state     <= ST_WAIT_VS;
            busy      <= 1'b1;
            frame_err <= 1'b0;
            line_cnt  <= '0;
            byte_cnt  <= '0;
          end
        ST_WAIT_VS:
          if (vs_fall) state <= ST_CAPTURE;
        ST_CAPTURE: begin
          // Dropped overflow bytes still advance byte_cnt so later addresses stay correct.
          if (accept)   byte_cnt  <= byte_cnt + 1'b1;
          if (overflow) frame_err <= 1'b1;
          if (href_fall) begin
            byte_cnt <= '0;
            if (line_cnt < LW'(HEIGHT)) line_cnt <= line_cnt + 1'b1;
          end
          if (line_cnt == LW'(HEIGHT)) begin
            state <= ST_DRAIN;
          end else if (vs_rise) begin
            state     <= ST_DRAIN;
            frame_err <= 1'b1;
          end
        end
        ST_DRAIN:
          if (fifo_empty) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_yuyv_frame_writer.sv
// Directed bench for yuyv_frame_writer on a reduced 16x3 frame (32 bytes/line, 96 bytes total).
module tb_yuyv_frame_writer;
  localparam int W  = 16;
  localparam int H  = 3;
  localparam int LB = 2 * W;
  localparam int FB = LB * H;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        capture_req = 1'b0, cam_vsync = 1'b1, cam_href = 1'b0, cam_valid = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        acc_lvl = 1'b1;
  int          acc_mode = 0;
  logic [1:0]  ph = 2'd0;
  logic        mem_wr_acc, mem_wr, busy, frame_done, frame_err;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;

  int n_tests = 0, n_fail = 0, test_id = 0;
  int mon_id = 0, wr_cnt = 0, done_cnt = 0, mono_bad = 0, data_bad = 0;
  int first_addr = 0, last_addr = 0;
  int seen_tag [FB];

  assign mem_wr_acc = (acc_mode != 0) ? (ph == 2'd0) : acc_lvl;

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;

  yuyv_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(17), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .capture_req(capture_req), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_valid(cam_valid), .cam_data(cam_data), .mem_wr_acc(mem_wr_acc),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  // Write monitor; its counters restart whenever the bench moves to a new test id.
  always @(negedge clk) begin
    if (mon_id != test_id) begin
      mon_id = test_id; wr_cnt = 0; done_cnt = 0; mono_bad = 0; data_bad = 0;
      first_addr = -1; last_addr = -1;
    end
    if (mem_wr) begin
      if (wr_cnt == 0) first_addr = int'(mem_addr);
      else if (int'(mem_addr) != last_addr + 1) mono_bad++;
      if (int'(mem_addr) < FB) seen_tag[int'(mem_addr)] = test_id;
      if (mem_data != mem_addr[7:0]) data_bad++;
      last_addr = int'(mem_addr);
      wr_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic new_test(input int id);
    test_id = id;
    step(2);
  endtask

  task automatic start_frame();
    capture_req = 1'b1; cam_vsync = 1'b1;
    step(2);
    capture_req = 1'b0;
    step(2);
    cam_vsync = 1'b0;
    step(2);
  endtask

  task automatic send_byte(input int l, input int b, input int gap);
    cam_data  = (l < H && b < LB) ? 8'(l * LB + b) : 8'hEE;
    cam_valid = 1'b1;
    step();
    cam_valid = 1'b0;
    step(gap);
  endtask

  task automatic send_line(input int l, input int nb, input int gap);
    cam_href = 1'b1;
    step();
    for (int b = 0; b < nb; b++) send_byte(l, b, gap);
    cam_href = 1'b0;
    step(3);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin step(); k++; end
    step(4);
    chk(tag, done_cnt, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk("rst_mem_wr", int'(mem_wr), 0);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_done",   int'(frame_done), 0);
    chk("rst_err",    int'(frame_err), 0);
    chk("rst_addr",   int'(mem_addr), 0);
    reset_n = 1'b1;
    step(2);

    // Nominal frame, one byte per cycle, grant always on.
    new_test(1);
    start_frame();
    chk("t1_busy_start", int'(busy), 1);
    for (int l = 0; l < H; l++) send_line(l, LB, 0);
    wait_done("t1_done");
    chk("t1_writes", wr_cnt, FB);
    chk("t1_first",  first_addr, 0);
    chk("t1_last",   last_addr, FB - 1);
    chk("t1_mono",   mono_bad, 0);
    chk("t1_data",   data_bad, 0);
    chk("t1_err",    int'(frame_err), 0);
    chk("t1_busy",   int'(busy), 0);
    cam_vsync = 1'b1; step(2);

    // Crop: oversized lines and extra lines never reach memory.
    new_test(2);
    start_frame();
    for (int l = 0; l < H + 2; l++) send_line(l, LB + 8, 1);
    wait_done("t2_done");
    chk("t2_writes", wr_cnt, FB);
    chk("t2_last",   last_addr, FB - 1);
    chk("t2_mono",   mono_bad, 0);
    chk("t2_data",   data_bad, 0);
    chk("t2_err",    int'(frame_err), 0);
    cam_vsync = 1'b1; step(2);

    // Grant 1 cycle in 4, byte every 8 cycles.
    new_test(3);
    acc_mode = 1;
    start_frame();
    for (int l = 0; l < H; l++) send_line(l, LB, 7);
    wait_done("t3_done");
    chk("t3_writes", wr_cnt, FB);
    chk("t3_mono",   mono_bad, 0);
    chk("t3_data",   data_bad, 0);
    chk("t3_err",    int'(frame_err), 0);
    acc_mode = 0;
    cam_vsync = 1'b1; step(2);

    // Overflow: no grant across 20 bytes of line 0.
    new_test(4);
    acc_lvl = 1'b0;
    start_frame();
    cam_href = 1'b1; step();
    for (int b = 0; b < 20; b++) send_byte(0, b, 1);
    chk("t4_nowr", wr_cnt, 0);
    acc_lvl = 1'b1;
    step(2);
    for (int b = 20; b < LB; b++) send_byte(0, b, 1);
    cam_href = 1'b0; step(3);
    for (int l = 1; l < H; l++) send_line(l, LB, 1);
    wait_done("t4_done");
    chk("t4_writes", wr_cnt, FB - 12);
    chk("t4_seen7",  int'(seen_tag[7] == 4), 1);
    chk("t4_seen8",  int'(seen_tag[8] == 4), 0);
    chk("t4_seen19", int'(seen_tag[19] == 4), 0);
    chk("t4_seen20", int'(seen_tag[20] == 4), 1);
    chk("t4_data",   data_bad, 0);
    chk("t4_last",   last_addr, FB - 1);
    chk("t4_err",    int'(frame_err), 1);
    cam_vsync = 1'b1; step(2);

    // Short frame: vsync rises after one line.
    new_test(5);
    start_frame();
    chk("t5_err_clr", int'(frame_err), 0);
    send_line(0, LB, 1);
    cam_vsync = 1'b1;
    begin
      int k;
      k = 0;
      while (k < 500) begin
        @(negedge clk);
        if (frame_done) break;
        k++;
      end
      chk("t5_done_seen", int'(frame_done), 1);
      chk("t5_busy_at_done", int'(busy), 1);
      @(negedge clk);
      chk("t5_busy_after", int'(busy), 0);
      chk("t5_done_once",  int'(frame_done), 0);
    end
    step(2);
    chk("t5_writes", wr_cnt, LB);
    chk("t5_err",    int'(frame_err), 1);
    chk("t5_mono",   mono_bad, 0);

    // Reset in the middle of line 1 with data sitting in the FIFO.
    new_test(6);
    acc_lvl = 1'b0;
    start_frame();
    send_line(0, LB, 1);
    cam_href = 1'b1; step();
    for (int b = 0; b < 4; b++) send_byte(1, b, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_mem_wr", int'(mem_wr), 0);
    chk("t6_busy",   int'(busy), 0);
    chk("t6_done",   int'(frame_done), 0);
    chk("t6_err",    int'(frame_err), 0);
    cam_href = 1'b0; cam_valid = 1'b0; cam_vsync = 1'b1; acc_lvl = 1'b1;
    step(3);
    chk("t6_nowr_in_rst", wr_cnt, 0);
    reset_n = 1'b1;
    step(2);

    new_test(7);
    start_frame();
    for (int l = 0; l < H; l++) send_line(l, LB, 0);
    wait_done("t7_done");
    chk("t7_first",  first_addr, 0);
    chk("t7_writes", wr_cnt, FB);
    chk("t7_mono",   mono_bad, 0);
    chk("t7_err",    int'(frame_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/yuyv_frame_writer.md
Name: yuyv_frame_writer

Overview:
- Camera-side producer for the YUYV frame buffer. It captures one OV7670 YUYV frame on request and writes the bytes in raster order into the shared single-port frame memory.
- The 8x8 block reader on the other port consumes that memory.
- Memory writes happen only while the reader grants access on mem_wr_acc. Bytes that arrive outside grant windows are held in a small address+data FIFO.

Parameters:
- WIDTH, 320, pixels per stored line (2 bytes per pixel).
- HEIGHT, 200, lines stored; camera lines beyond this are discarded.
- ADDR_W, 17, frame memory byte address width; WIDTH*HEIGHT*2 must be <= 2^ADDR_W.
- FIFO_DEPTH, 8, entries in the write FIFO; must be a power of 2 and >= 4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- capture_req  in  1  level request; its rising edge starts one frame capture.
- cam_vsync  in  1  camera VSYNC, already synchronised to clk; high = frame blanking.
- cam_href  in  1  camera HREF, synchronised; high = active line.
- cam_valid  in  1  one-cycle strobe, one per camera byte.
- cam_data  in  8  camera byte, qualified by cam_valid.
- mem_wr_acc  in  1  memory write grant from the reader.
- mem_addr  out  ADDR_W  write address (FIFO head).
- mem_data  out  8  write data (FIFO head).
- mem_wr  out  1  write strobe.
- busy  out  1  capture in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_err  out  1  sticky error flag; cleared on the next capture start.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, all counters 0.
- Edge detect: capture_req, cam_vsync and cam_href each use a 1-cycle delayed copy.
- States:
  - IDLE: on capture_req rising edge -> WAIT_VS; clear frame_err, line_cnt and byte_cnt.
  - WAIT_VS: on cam_vsync falling edge -> CAPTURE. Bytes arriving here are ignored.
  - CAPTURE:
    - Byte accept: cam_valid & cam_href & line_cnt<HEIGHT & byte_cnt<2*WIDTH.
    - On accept: push {line_cnt*2*WIDTH + byte_cnt, cam_data}, then byte_cnt++.
    - Bytes failing the line or row limit are dropped silently.
    - cam_href falling edge: byte_cnt<=0; line_cnt++ saturating at HEIGHT.
    - line_cnt reaching HEIGHT -> DRAIN.
    - cam_vsync rising edge with line_cnt<HEIGHT -> DRAIN and set frame_err (short frame).
  - DRAIN: no pushes. When the FIFO is empty -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
- busy = (state != IDLE).
- Byte order: bytes are stored unmodified in camera order Y0 U Y1 V. No sign conversion is done here.
- FIFO and memory write:
  - mem_wr = !fifo_empty & mem_wr_acc (combinational).
  - mem_addr and mem_data show the FIFO head. The pop happens on the same clk edge as mem_wr.
  - Push and pop in the same cycle are allowed, including when full (count unchanged) and when empty-with-push (no bypass; data is written at the earliest one cycle later).
- Overflow: an accepted byte arriving while the FIFO is full, with no same-cycle pop, is dropped, sets frame_err, and still advances byte_cnt. Later bytes therefore keep correct addresses.
- Address arithmetic is done at ADDR_W bits with no wrap. The maximum address is 2*WIDTH*HEIGHT-1 = 127999.
- capture_req edges while busy are ignored.
- Reset mid-frame: FIFO flushed and no further mem_wr. Memory contents are left undefined.
- Latency: cam_valid to earliest mem_wr is 1 cycle.

Decomposition:
- Shared package (used with the block reader):
  - constants FRAME_WIDTH, FRAME_HEIGHT, FRAME_BPP, FRAME_ADDR_W;
  - a state enum for this block.
- Sub-module: wr_addr_fifo, a synchronous FIFO of width ADDR_W+8 and depth FIFO_DEPTH, with push, pop, full, empty and count. The existing sc_fifo is not reused because its data width is fixed at 8.

Test Plan:
1. Nominal frame: capture_req pulse, then vsync 1->0, then 200 lines of 640 bytes (data = address[7:0]), mem_wr_acc tied 1 -> 128000 writes, each mem_data == mem_addr[7:0], last address 127999; frame_done pulses once; frame_err=0.
2. Crop: camera sends 240 lines of 700 bytes -> bytes 640..699 of each line and lines 200..239 never written; write count 128000; no error.
3. Grant gating: mem_wr_acc high 1 cycle in 4, cam_valid every 8 cycles -> no overflow; every write address strictly increasing by 1.
4. Overflow: mem_wr_acc=0 for 20 consecutive bytes, FIFO_DEPTH=8 -> first 8 bytes written after the grant returns, 12 dropped; frame_err=1; byte 21 written at its correct address (line base + 20).
5. Short frame: vsync rises after line 50 -> DRAIN, FIFO empties, frame_done pulses; frame_err=1; busy falls the cycle after frame_done.
6. Reset mid-frame: assert reset_n=0 during line 10 -> mem_wr=0, busy=0, frame_done=0 immediately; a new capture after release starts at address 0.
